// File: rtl/switch_input_fifo.sv
// Switch snapshot FIFO: captures synchronized board switches on each debounced key pulse for in-order CPU reads.
// Optional SWIN_IRQ_EN adds a registered level interrupt that mirrors !empty.
module switch_input_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  key_pulse,
  input  logic [DATA_W-1:0]     sw_in,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
`ifdef SWIN_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     swMeta_q;
  logic [DATA_W-1:0]     swSync_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  doPush, doPop, dropPush;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? '0 : mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  assign doPop    = rd_en && !empty;
  assign doPush   = key_pulse && (!full || doPop);
  assign dropPush = key_pulse && full && !doPop;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    if (doPush && !doPop)      count_d = count_q + CNT_ONE;
    else if (!doPush && doPop) count_d = count_q - CNT_ONE;
    if (dropPush)     overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      swMeta_q   <= '0;
      swSync_q   <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      swMeta_q   <= sw_in;
      swSync_q   <= swMeta_q;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; rd_data is masked while empty so stale words never leak out.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= swSync_q;
  end

`ifdef SWIN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= (count_d != '0);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_input_fifo.sv
// Directed, table-driven bench for switch_input_fifo (depth 4); irq checks compile in only with SWIN_IRQ_EN.
module tb_switch_input_fifo;

  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 2;
  localparam int NVEC       = 21;

  logic              clk = 1'b0;
  logic              rstn;
  logic              key_pulse;
  logic [DATA_W-1:0] sw_in;
  logic              rd_en;
  logic              ovf_clr;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [DEPTH_LOG2:0] count;
  logic              overflow;
`ifdef SWIN_IRQ_EN
  logic              irq;
`endif

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [15:0] data;
    logic [2:0]  expCount;
    logic [15:0] expRd;
    logic        expEmpty;
    logic        expFull;
    logic        expOvf;
  } vec_t;

  vec_t vecs [NVEC];
  int   checkCount = 0;
  int   passCount  = 0;

  switch_input_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_pulse (key_pulse),
    .sw_in     (sw_in),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
`ifdef SWIN_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Compares every output against expectations; irq must always mirror !empty.
  task automatic checkState(input string tag, input logic [2:0] cnt, input logic [15:0] rd,
                            input logic emp, input logic fl, input logic ovf);
    checkOutput({tag, " count"},    32'(count),    32'(cnt));
    checkOutput({tag, " rd_data"},  32'(rd_data),  32'(rd));
    checkOutput({tag, " empty"},    32'(empty),    32'(emp));
    checkOutput({tag, " full"},     32'(full),     32'(fl));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(ovf));
`ifdef SWIN_IRQ_EN
    checkOutput({tag, " irq"},      32'(irq),      32'(!emp));
`endif
  endtask

  task automatic setVec(input int i, input logic push, input logic pop, input logic clr,
                        input logic [15:0] data, input logic [2:0] cnt, input logic [15:0] rd,
                        input logic emp, input logic fl, input logic ovf);
    vecs[i].push     = push;
    vecs[i].pop      = pop;
    vecs[i].clr      = clr;
    vecs[i].data     = data;
    vecs[i].expCount = cnt;
    vecs[i].expRd    = rd;
    vecs[i].expEmpty = emp;
    vecs[i].expFull  = fl;
    vecs[i].expOvf   = ovf;
  endtask

  // Lets sw_in settle through the synchronizer, then fires the controls for exactly one edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    sw_in     = v.data;
    key_pulse = 1'b0;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    key_pulse = v.push;
    rd_en     = v.pop;
    ovf_clr   = v.clr;
    @(negedge clk);
    key_pulse = 1'b0;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    //          push pop clr data      cnt rd        emp full ovf
    setVec( 0, 1, 0, 0, 16'hA5A5, 1, 16'hA5A5, 0, 0, 0);
    setVec( 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    setVec( 2, 1, 0, 0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    setVec( 3, 1, 0, 0, 16'h0002, 2, 16'h0001, 0, 0, 0);
    setVec( 4, 1, 0, 0, 16'h0003, 3, 16'h0001, 0, 0, 0);
    setVec( 5, 1, 0, 0, 16'h0004, 4, 16'h0001, 0, 1, 0);
    setVec( 6, 0, 1, 0, 16'h0000, 3, 16'h0002, 0, 0, 0);
    setVec( 7, 0, 1, 0, 16'h0000, 2, 16'h0003, 0, 0, 0);
    setVec( 8, 1, 0, 0, 16'h0005, 3, 16'h0003, 0, 0, 0);
    setVec( 9, 1, 0, 0, 16'h0006, 4, 16'h0003, 0, 1, 0);
    setVec(10, 1, 0, 0, 16'h0007, 4, 16'h0003, 0, 1, 1);
    setVec(11, 1, 0, 1, 16'h0008, 4, 16'h0003, 0, 1, 1);
    setVec(12, 0, 0, 1, 16'h0000, 4, 16'h0003, 0, 1, 0);
    setVec(13, 1, 1, 0, 16'h0009, 4, 16'h0004, 0, 1, 0);
    setVec(14, 0, 1, 0, 16'h0000, 3, 16'h0005, 0, 0, 0);
    setVec(15, 0, 1, 0, 16'h0000, 2, 16'h0006, 0, 0, 0);
    setVec(16, 0, 1, 0, 16'h0000, 1, 16'h0009, 0, 0, 0);
    setVec(17, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    setVec(18, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    setVec(19, 1, 1, 0, 16'h1234, 1, 16'h1234, 0, 0, 0);
    setVec(20, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);

    rstn      = 1'b0;
    key_pulse = 1'b0;
    rd_en     = 1'b0;
    ovf_clr   = 1'b0;
    sw_in     = '0;
    #12;
    checkState("reset", 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkState($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expRd,
                 vecs[i].expEmpty, vecs[i].expFull, vecs[i].expOvf);
    end

    // Pulse one edge after sw_in changes: the two-flop synchronizer still holds the old value.
    @(negedge clk);
    sw_in = 16'h1111;
    repeat (3) @(negedge clk);
    sw_in = 16'h2222;
    @(negedge clk);
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    checkState("syncStale", 3'd1, 16'h1111, 1'b0, 1'b0, 1'b0);

    // A key held for two cycles yields two pushes.
    @(negedge clk);
    key_pulse = 1'b1;
    repeat (2) @(negedge clk);
    key_pulse = 1'b0;
    checkState("heldKey", 3'd3, 16'h1111, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    key_pulse = 1'b1;
    @(negedge clk);
    checkState("fillHeld", 3'd4, 16'h1111, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    key_pulse = 1'b0;
    checkState("dropHeld", 3'd4, 16'h1111, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle flushes everything without waiting for an edge.
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checkState("asyncReset", 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkState("postReset", 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
